// File: rtl/inverter_pkg.sv
// Shared constants and the fill-state type for the byte_inverter datapath.
package inverter_pkg;

   localparam int INV_WIDTH_DEFAULT = 8;
   localparam logic [INV_WIDTH_DEFAULT-1:0] INV_MASK_ALL = '1;

   // Occupancy of the two-entry output buffer: nothing, output register only, both entries.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_HALF  = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_t;

endpackage

// File: rtl/inverter_skid.sv
// Generic two-entry ready/valid buffer: an output register backed by a skid register.
// in_ready and out_valid are flops, so no combinational path crosses the stage.
module inverter_skid
   import inverter_pkg::*;
#(
   parameter int WIDTH = INV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready
);

   skid_state_t      state_r;
   skid_state_t      state_next;
   logic [WIDTH-1:0] out_r;
   logic [WIDTH-1:0] out_next;
   logic [WIDTH-1:0] skid_r;
   logic [WIDTH-1:0] skid_next;
   logic             out_valid_r;
   logic             in_ready_r;
   logic             in_fire;
   logic             out_fire;

   assign in_fire   = in_valid & in_ready_r;
   assign out_fire  = out_valid_r & out_ready;
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out       = out_r;

   always_comb begin
      state_next = state_r;
      out_next   = out_r;
      skid_next  = skid_r;
      case (state_r)
         SKID_EMPTY: begin
            if (in_fire) begin
               out_next   = in;
               state_next = SKID_HALF;
            end else begin
               state_next = SKID_EMPTY;
            end
         end
         SKID_HALF: begin
            // A simultaneous in/out transfer refills the output register directly.
            if (in_fire && out_fire) begin
               out_next = in;
            end else if (in_fire) begin
               skid_next  = in;
               state_next = SKID_FULL;
            end else if (out_fire) begin
               state_next = SKID_EMPTY;
            end else begin
               state_next = SKID_HALF;
            end
         end
         SKID_FULL: begin
            if (out_fire) begin
               out_next   = skid_r;
               state_next = SKID_HALF;
            end else begin
               state_next = SKID_FULL;
            end
         end
         default: begin
            state_next = SKID_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= SKID_EMPTY;
         out_r       <= '0;
         skid_r      <= '0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_next;
         out_r       <= out_next;
         skid_r      <= skid_next;
         out_valid_r <= (state_next != SKID_EMPTY);
         in_ready_r  <= (state_next != SKID_FULL);
      end
   end

endmodule

// File: rtl/byte_inverter.sv
// Flow-controlled per-bit inverter: out = in ^ mask, through a registered skid stage
// or, with REGISTERED = 0, as a purely combinational pass-through.
module byte_inverter
   import inverter_pkg::*;
#(
   parameter int WIDTH      = INV_WIDTH_DEFAULT,
   parameter bit REGISTERED = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] mask,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [WIDTH-1:0] word;

   assign word = in ^ mask;

   generate
      if (REGISTERED) begin : g_reg
         inverter_skid #(
            .WIDTH(WIDTH)
         ) u_skid (
            .clk      (clk),
            .rst_n    (rst_n),
            .in       (word),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .out      (out),
            .out_valid(out_valid),
            .out_ready(out_ready)
         );
      end else begin : g_comb
         assign out       = word;
         assign out_valid = in_valid;
         assign in_ready  = out_ready;
      end
   endgenerate

endmodule

// File: tb/tb_byte_inverter.sv
// Self-checking bench for byte_inverter: queue scoreboard on the registered build,
// directed checks on a combinational build.
module tb_byte_inverter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in, mask;
   logic       in_valid, out_ready;
   logic       in_ready, out_valid;
   logic [7:0] out;

   logic [7:0] c_in, c_mask;
   logic       c_in_valid, c_out_ready;
   logic       c_in_ready, c_out_valid;
   logic [7:0] c_out;

   int         total = 0;
   int         bad   = 0;
   bit         live  = 1'b0;
   logic [7:0] q[$];

   always #5 clk = ~clk;

   byte_inverter #(.WIDTH(8), .REGISTERED(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in(in), .mask(mask), .in_valid(in_valid),
      .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready)
   );

   byte_inverter #(.WIDTH(8), .REGISTERED(1'b0)) dut_comb (
      .clk(clk), .rst_n(rst_n), .in(c_in), .mask(c_mask), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .out(c_out), .out_valid(c_out_valid), .out_ready(c_out_ready)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: check against the scoreboard before the edge, apply transfers, advance to negedge.
   task automatic tick();
      bit in_fire, out_fire;
      #1;
      in_fire  = rst_n && in_valid && in_ready;
      out_fire = rst_n && out_valid && out_ready;
      if (live && rst_n) begin
         chk("out_valid", {7'd0, out_valid}, {7'd0, q.size() != 0});
         chk("in_ready", {7'd0, in_ready}, {7'd0, q.size() < 2});
         if (q.size() != 0) chk("out_data", out, q[0]);
      end
      if (out_fire && q.size() != 0) void'(q.pop_front());
      if (in_fire) q.push_back(in ^ mask);
      @(posedge clk);
      if (!rst_n) q.delete();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; in = 8'h00; mask = 8'hFF; in_valid = 1'b0; out_ready = 1'b1;
      c_in = 8'h00; c_mask = 8'hFF; c_in_valid = 1'b0; c_out_ready = 1'b0;

      // reset held for two edges
      tick(); tick();
      rst_n = 1'b1; live = 1'b1;
      #1;
      chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
      chk("rst_out", out, 8'h00);
      chk("rst_in_ready", {7'd0, in_ready}, 8'd1);

      // plain inversion, one word per cycle
      in_valid = 1'b1; mask = 8'hFF;
      in = 8'hF0; tick(); chk("inv_F0", out, 8'h0F);
      in = 8'hAA; tick(); chk("inv_AA", out, 8'h55);
      in = 8'h33; tick(); chk("inv_33", out, 8'hCC);
      in = 8'hE7; tick(); chk("inv_E7", out, 8'h18);
      chk("inv_valid", {7'd0, out_valid}, 8'd1);

      // partial masks
      in = 8'hF0; mask = 8'h0F; tick(); chk("mask_0F", out, 8'hFF);
      in = 8'hAA; mask = 8'h00; tick(); chk("mask_00", out, 8'hAA);
      in_valid = 1'b0; mask = 8'h5A; tick();
      chk("drain_valid", {7'd0, out_valid}, 8'd0);

      // backpressure: EE held, DD skidded, 33 refused until space frees
      out_ready = 1'b0; in_valid = 1'b1; mask = 8'hFF;
      in = 8'h11; tick(); chk("bp_hold1", out, 8'hEE);
      in = 8'h22; tick(); chk("bp_hold2", out, 8'hEE);
      chk("bp_ready_drop", {7'd0, in_ready}, 8'd0);
      in = 8'h33; tick(); chk("bp_hold3", out, 8'hEE);
      chk("bp_still_valid", {7'd0, out_valid}, 8'd1);
      out_ready = 1'b1;
      tick(); chk("bp_second", out, 8'hDD);
      chk("bp_ready_back", {7'd0, in_ready}, 8'd1);
      tick(); chk("bp_third", out, 8'hCC);
      in_valid = 1'b0; tick();
      chk("bp_empty", {7'd0, out_valid}, 8'd0);

      // random mix of traffic and backpressure through the scoreboard
      for (int i = 0; i < 60; i++) begin
         in        = 8'($urandom_range(0, 255));
         mask      = 8'($urandom_range(0, 255));
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // reset with both entries full, input attempted on the reset edge
      out_ready = 1'b0; in_valid = 1'b1; mask = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         in = 8'h40 + 8'(i); tick();
      end
      chk("mid_full", {7'd0, in_ready}, 8'd0);
      rst_n = 1'b0; in = 8'h99; tick();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("mid_out_valid", {7'd0, out_valid}, 8'd0);
      chk("mid_in_ready", {7'd0, in_ready}, 8'd1);
      chk("mid_out", out, 8'h00);
      tick(); tick(); tick();
      chk("mid_no_stale", {7'd0, out_valid}, 8'd0);

      // combinational build
      c_in = 8'h0F; c_mask = 8'hFF; c_in_valid = 1'b1; c_out_ready = 1'b0;
      #1;
      chk("comb_out", c_out, 8'hF0);
      chk("comb_valid", {7'd0, c_out_valid}, 8'd1);
      chk("comb_ready0", {7'd0, c_in_ready}, 8'd0);
      c_out_ready = 1'b1; c_in_valid = 1'b0; c_mask = 8'h3C;
      #1;
      chk("comb_ready1", {7'd0, c_in_ready}, 8'd1);
      chk("comb_valid0", {7'd0, c_out_valid}, 8'd0);
      chk("comb_partial", c_out, 8'h33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/byte_inverter.md
# byte_inverter

Registered, flow-controlled bitwise inverter. Each accepted input word is XORed with a per-bit invert mask (all-ones gives the plain one's complement, e.g. 8'hF0 → 8'h0F) and presented on a valid/ready output stage. It sits between a producer and a consumer in a datapath that needs word-wide negation without breaking the ready/valid chain or adding combinational ready paths.

## Interface
- WIDTH, 8, data width in bits (≥1).
- REGISTERED, 1, 1 = registered output stage with skid buffer; 0 = purely combinational pass-through.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- in  input  WIDTH  input data word.
- mask  input  WIDTH  per-bit invert select (1 = invert the bit); tie to all-ones for a pure inverter.
- in_valid  input  1  `in`/`mask` hold a word.
- in_ready  output  1  block can accept a word this cycle.
- out  output  WIDTH  result word, `in ^ mask` of the accepted beat.
- out_valid  output  1  `out` holds a word.
- out_ready  input  1  consumer accepts `out` this cycle.

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge.
- Transfer out: `out_valid && out_ready` at a rising edge.
- Result: `out = in ^ mask`, computed from the `in` and `mask` values sampled at the input transfer edge. `mask` has no effect outside transfer edges.
- Storage: a 2-entry buffer, made up of an output register and a skid register.
  - `in_ready` comes straight from a register (skid empty). There is no combinational path from `out_ready` to `in_ready`.
- Ordering: strict FIFO, no drops, no duplicates.
- Simultaneous in/out transfer with the output register full and the skid empty: the output register loads the new word and the skid stays empty.
- Skid full: `in_ready = 0`.
  - On the next output transfer, the skid word moves to the output register.
  - `in_ready` returns to 1 on the following cycle.
- With `REGISTERED = 0`:
  - `out = in ^ mask`, `out_valid = in_valid`, `in_ready = out_ready`, all combinational.
  - `clk` and `rst_n` are unused.

## Timing
- Reset is sampled on the rising edge of `clk` while `rst_n = 0`. After that edge:
  - `out_valid = 0`, `out = 0`, `in_ready = 1`, skid empty.
  - Words accepted before reset are discarded.
  - Any input transfer attempted on the reset edge is ignored.
- Latency: a word accepted at edge k appears on `out` with `out_valid = 1` immediately after edge k.
- Throughput: one word per cycle while `out_ready = 1`.
- Backpressure: while `out_valid = 1 && out_ready = 0`, `out` and `out_valid` hold stable.
- Reset mid-stream: the buffer empties at the reset edge regardless of `out_ready`.

## Structure
- Shared package `inverter_pkg`:
  - `INV_WIDTH_DEFAULT = 8`.
  - `INV_MASK_ALL = '1` (all-ones mask constant).
- Sub-module `inverter_skid`:
  - Generic WIDTH-bit 2-entry ready/valid skid buffer.
  - Operates on the post-XOR word.
  - `byte_inverter` is the XOR plus this sub-module, with a generate bypass for `REGISTERED = 0`.

## Test plan
- Reset: hold `rst_n = 0` for 2 edges, then release → `out_valid = 0`, `out = 8'h00`, `in_ready = 1`.
- Plain inversion, mask = 8'hFF, `out_ready = 1`, one word per cycle: F0, AA, 33, E7 → `out` = 0F, 55, CC, 18 on consecutive cycles, each 1 cycle after acceptance.
- Partial mask: in = 8'hF0, mask = 8'h0F → `out` = 8'hFF. In = 8'hAA, mask = 8'h00 → `out` = 8'hAA.
- Backpressure:
  - Stimulus: `out_ready = 0`, stream 11, 22, 33 with mask = FF.
  - Required response: EE is held on `out`; 22 is accepted into the skid; `in_ready` drops before 33.
  - Then raise `out_ready` → `out` = EE, DD, CC in order, no loss.
- Reset mid-stream: with both entries full, assert `rst_n = 0` for 1 edge → `out_valid = 0`, `in_ready = 1`, and no stale word appears afterwards.
- `REGISTERED = 0` build: in = 8'h0F, mask = FF → `out = 8'hF0` in the same cycle, and `in_ready` follows `out_ready` combinationally.
